// File: rtl/line_buffer_pkg.sv
// Shared types and helpers for the multi-flux line-delay actor.
// Holds the per-flux state encoding, tag sizing and size-token clamping.
package line_buffer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_t;

  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A zero-sized row still carries one pixel; oversized rows saturate to storage width.
  function automatic int clamp_size(input int v, input int max_line);
    if (v <= 0) return 1;
    if (v > max_line) return max_line;
    return v;
  endfunction

endpackage

// File: rtl/line_buffer_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner whenever the grant is used.
module rr_arbiter
  import line_buffer_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = tag_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [IW-1:0] grant,
  output logic          grant_valid
);

  logic [IW-1:0] ptr;

  // Scan downward so the requester closest to the pointer is assigned last and wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        grant       = IW'((int'(ptr) + i) % N);
        grant_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && grant_valid) begin
      ptr <= (int'(grant) + 1 >= N) ? '0 : grant + 1'b1;
    end
  end

endmodule

// File: rtl/line_buffer_rr.sv
// Multi-flux line delay: each pixel consumed is replaced by the pixel at the same
// column NUM_LINES rows earlier, with one flux served per cycle in round-robin order.
module line_buffer_rr
  import line_buffer_pkg::*;
#(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 18,
  parameter int SIZE_WIDTH = 7,
  parameter int MAX_LINE   = 64,
  parameter int NUM_LINES  = 1,
  localparam int TAG_WIDTH = tag_width(FLUX)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [FLUX-1:0]                  read_port_ext_size_empty,
  output logic [FLUX-1:0]                  read_port_ext_size_read,
  input  logic [SIZE_WIDTH+TAG_WIDTH-1:0]  read_port_ext_size_dout [FLUX],
  input  logic [FLUX-1:0]                  read_port_real_size_empty,
  output logic [FLUX-1:0]                  read_port_real_size_read,
  input  logic [SIZE_WIDTH+TAG_WIDTH-1:0]  read_port_real_size_dout [FLUX],
  input  logic [FLUX-1:0]                  read_port_in_pel_empty,
  output logic [FLUX-1:0]                  read_port_in_pel_read,
  input  logic [DATA_WIDTH+TAG_WIDTH-1:0]  read_port_in_pel_dout [FLUX],
  input  logic [FLUX-1:0]                  write_port_out_pel_full,
  output logic [FLUX-1:0]                  write_port_out_pel_write,
  output logic [DATA_WIDTH+TAG_WIDTH-1:0]  write_port_out_pel_din
);

  localparam int CW    = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
  localparam int LW    = $clog2(MAX_LINE + 1);
  localparam int RW    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int DEPTH = FLUX * NUM_LINES * MAX_LINE;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t                state   [FLUX];
  logic [CW-1:0]         cnt_h   [FLUX];
  logic [SIZE_WIDTH-1:0] cnt_v   [FLUX];
  logic [LW-1:0]         w       [FLUX];
  logic [SIZE_WIDTH-1:0] h       [FLUX];
  logic [RW-1:0]         row_ptr [FLUX];
  logic [DATA_WIDTH-1:0] mem     [DEPTH];

  logic [FLUX-1:0]       ready;
  logic [TAG_WIDTH-1:0]  sel;
  logic                  fire;
  logic [AW-1:0]         addr;
  logic                  last_col;
  logic                  last_row;
  logic [SIZE_WIDTH-1:0] ext_val;
  logic [SIZE_WIDTH-1:0] real_val;
  logic                  unused_tag_bits;

  function automatic logic [RW-1:0] next_row(input logic [RW-1:0] r);
    return (int'(r) >= NUM_LINES - 1) ? '0 : r + 1'b1;
  endfunction

  // Readiness is independent of state priority; the arbiter alone picks the winner.
  always_comb begin
    for (int f = 0; f < FLUX; f++) begin
      if (state[f] == IDLE)
        ready[f] = !rst && !read_port_ext_size_empty[f] && !read_port_real_size_empty[f];
      else
        ready[f] = !rst && !read_port_in_pel_empty[f] && !write_port_out_pel_full[f];
    end
  end

  rr_arbiter #(.N(FLUX)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (ready),
    .advance     (fire),
    .grant       (sel),
    .grant_valid (fire)
  );

  always_comb begin
    addr     = AW'((int'(sel) * NUM_LINES + int'(row_ptr[sel])) * MAX_LINE + int'(cnt_h[sel]));
    last_col = int'(cnt_h[sel]) + 1 >= int'(w[sel]);
    last_row = int'(cnt_v[sel]) + 1 >= int'(h[sel]);
    ext_val  = read_port_ext_size_dout[sel][SIZE_WIDTH-1:0];
    real_val = read_port_real_size_dout[sel][SIZE_WIDTH-1:0];
  end

  // Output carries the value stored before this cycle's write (read-before-write).
  always_comb begin
    read_port_ext_size_read  = '0;
    read_port_real_size_read = '0;
    read_port_in_pel_read    = '0;
    write_port_out_pel_write = '0;
    write_port_out_pel_din   = {sel, mem[addr]};
    if (fire) begin
      if (state[sel] == IDLE) begin
        read_port_ext_size_read[sel]  = 1'b1;
        read_port_real_size_read[sel] = 1'b1;
      end else begin
        read_port_in_pel_read[sel]    = 1'b1;
        write_port_out_pel_write[sel] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < FLUX; f++) begin
        state[f]   <= IDLE;
        cnt_h[f]   <= '0;
        cnt_v[f]   <= '0;
        w[f]       <= '0;
        h[f]       <= '0;
        row_ptr[f] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (fire) begin
      if (state[sel] == IDLE) begin
        w[sel]     <= LW'(clamp_size(int'(real_val), MAX_LINE));
        h[sel]     <= (ext_val == '0) ? SIZE_WIDTH'(1) : ext_val;
        cnt_h[sel] <= '0;
        cnt_v[sel] <= '0;
        state[sel] <= WORK;
      end else begin
        mem[addr] <= read_port_in_pel_dout[sel][DATA_WIDTH-1:0];
        if (!last_col) begin
          cnt_h[sel] <= cnt_h[sel] + 1'b1;
        end else begin
          cnt_h[sel]   <= '0;
          row_ptr[sel] <= next_row(row_ptr[sel]);
          if (!last_row) begin
            cnt_v[sel] <= cnt_v[sel] + 1'b1;
          end else begin
            cnt_v[sel] <= '0;
            state[sel] <= IDLE;
          end
        end
      end
    end
  end

  always_comb begin
    unused_tag_bits = 1'b0;
    for (int f = 0; f < FLUX; f++) begin
      unused_tag_bits = unused_tag_bits
        ^ (^read_port_ext_size_dout[f][SIZE_WIDTH+TAG_WIDTH-1:SIZE_WIDTH])
        ^ (^read_port_real_size_dout[f][SIZE_WIDTH+TAG_WIDTH-1:SIZE_WIDTH])
        ^ (^read_port_in_pel_dout[f][DATA_WIDTH+TAG_WIDTH-1:DATA_WIDTH]);
    end
  end

endmodule
